// File: rtl/reg_writeback.sv
// Register-file write-back arbiter: merges a fixed-latency pipeline result stream
// with a buffered long-latency result stream into one registered write port.
module reg_writeback #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] rd_write_data,
  output logic [31:0] busy_mask,
  output logic        stall_req
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

  logic [4:0]        fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]        fifo_rd_d   [FIFO_DEPTH];
  logic [31:0]       fifo_data_q [FIFO_DEPTH];
  logic [31:0]       fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       busy_q, busy_d;
  logic              reg_write_q, reg_write_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       data_q, data_d;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              sel_pipe;
  logic [4:0]        head_rd;
  logic [31:0]       head_data;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  assign lsu_ready = rst_n && !full;
  assign stall_req = rst_n && (wait_cnt_q == LIMIT_C);

  // A starving head pre-empts the pipeline; a pipeline result arriving while
  // stall_req is high is dropped rather than delayed.
  assign push     = lsu_valid && lsu_ready;
  assign pop      = !empty && (stall_req || !pipe_valid);
  assign sel_pipe = pipe_valid && !stall_req;

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = lsu_rd;
      fifo_data_d[wr_ptr_q] = lsu_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (empty || pop) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT_C) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_comb begin
    reg_write_d = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    if (pop) begin
      reg_write_d = (head_rd != 5'd0);
      rd_d        = head_rd;
      data_d      = head_data;
    end else if (sel_pipe) begin
      reg_write_d = (pipe_rd != 5'd0);
      rd_d        = pipe_rd;
      data_d      = pipe_data;
    end
  end

  // Clear first, then set, so a new issue to the same register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (pop && (head_rd != 5'd0)) begin
      busy_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_cnt_q  <= '0;
      busy_q      <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign rd            = rd_q;
  assign rd_write_data = data_q;
  assign busy_mask     = busy_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: hand-computed expectations for each vector.
module tb_reg_writeback;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] rd_write_data;
  logic [31:0] busy_mask;
  logic        stall_req;

  int total;
  int bad;

  reg_writeback #(.FIFO_DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_valid    (pipe_valid),
    .pipe_rd       (pipe_rd),
    .pipe_data     (pipe_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .RegWrite      (RegWrite),
    .rd            (rd),
    .rd_write_data (rd_write_data),
    .busy_mask     (busy_mask),
    .stall_req     (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid  = 1'b0;
    pipe_rd     = '0;
    pipe_data   = '0;
    lsu_valid   = 1'b0;
    lsu_rd      = '0;
    lsu_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic expect_wb(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    check({tag, "_we"}, 32'(RegWrite), 32'(we));
    check({tag, "_rd"}, 32'(rd), 32'(r));
    check({tag, "_data"}, rd_write_data, d);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(lsu_ready), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    expect_wb("rst", 1'b0, 5'd0, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", 32'(lsu_ready), 32'd1);

    // plain pipeline write, then hold on idle
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    expect_wb("pipe", 1'b1, 5'd5, 32'hDEADBEEF);
    idle();
    tick();
    expect_wb("hold", 1'b0, 5'd5, 32'hDEADBEEF);

    // issue r7, push result, drained with no pipeline competition
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    check("busy7_set", busy_mask, 32'h0000_0080);
    idle();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
    tick();
    check("nobypass_we", 32'(RegWrite), 32'd0);
    check("busy7_held", busy_mask, 32'h0000_0080);
    check("ready_one", 32'(lsu_ready), 32'd1);
    idle();
    tick();
    expect_wb("lsu7", 1'b1, 5'd7, 32'h1234);
    check("busy7_clr", busy_mask, 32'd0);

    // fill buffer under a continuous pipeline stream until starvation forces priority
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h100;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA0;
    tick();
    expect_wb("s_p1", 1'b1, 5'd1, 32'h100);
    pipe_rd = 5'd2; pipe_data = 32'h200;
    lsu_rd = 5'd11; lsu_data = 32'hB0;
    tick();
    expect_wb("s_p2", 1'b1, 5'd2, 32'h200);
    check("full_ready", 32'(lsu_ready), 32'd0);
    check("stall_w1", 32'(stall_req), 32'd0);
    lsu_valid = 1'b0;
    pipe_rd = 5'd3; pipe_data = 32'h300;
    tick();
    check("stall_w2", 32'(stall_req), 32'd0);
    pipe_rd = 5'd4; pipe_data = 32'h400;
    tick();
    expect_wb("s_p4", 1'b1, 5'd4, 32'h400);
    check("stall_w3", 32'(stall_req), 32'd1);
    pipe_rd = 5'd6; pipe_data = 32'h600;
    tick();
    expect_wb("starve_head", 1'b1, 5'd10, 32'hA0);
    check("stall_drop", 32'(stall_req), 32'd0);
    check("ready_back", 32'(lsu_ready), 32'd1);
    pipe_rd = 5'd5; pipe_data = 32'h500;
    tick();
    expect_wb("s_p5", 1'b1, 5'd5, 32'h500);
    idle();
    tick();
    expect_wb("second_head", 1'b1, 5'd11, 32'hB0);

    // writes to r0 are consumed silently
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h77;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFF;
    tick();
    check("r0_pipe_we", 32'(RegWrite), 32'd0);
    idle();
    tick();
    check("r0_lsu_we", 32'(RegWrite), 32'd0);
    check("r0_ready", 32'(lsu_ready), 32'd1);
    tick();
    check("r0_drained", 32'(RegWrite), 32'd0);

    // re-issue to a register in the same cycle its result pops
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    tick();
    check("busy9_pre", busy_mask, 32'h0000_0200);
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    expect_wb("lsu9", 1'b1, 5'd9, 32'h99);
    check("busy9_setwins", busy_mask, 32'h0000_0200);
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    check("busy_bit0", busy_mask, 32'h0000_0200);

    // reset with a full buffer and pending bits
    idle();
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC;
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    pipe_rd = 5'd2; pipe_data = 32'h22;
    lsu_rd = 5'd13; lsu_data = 32'hD;
    issue_rd = 5'd13;
    tick();
    check("pre_rst_ready", 32'(lsu_ready), 32'd0);
    check("pre_rst_busy", busy_mask, 32'h0000_3200);
    rst_n = 1'b0;
    pipe_rd = 5'd20; pipe_data = 32'h2020;
    lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'hE;
    issue_rd = 5'd14;
    #1;
    check("in_rst_ready", 32'(lsu_ready), 32'd0);
    tick();
    check("in_rst_stall", 32'(stall_req), 32'd0);
    expect_wb("post_rst", 1'b0, 5'd0, 32'd0);
    check("post_rst_busy", busy_mask, 32'd0);
    rst_n = 1'b1;
    idle();
    #1;
    check("rel2_ready", 32'(lsu_ready), 32'd1);
    tick();
    check("rel2_we", 32'(RegWrite), 32'd0);
    check("rel2_busy", busy_mask, 32'd0);
    tick();
    check("rel2_we2", 32'(RegWrite), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
